// File: rtl/snake_pix_if.sv
// Pixel request/response bundle between the scan/game logic and the compositor.
// rdn is a one-way request with no backpressure. Each cycle with rdn=0 yields exactly one
// result, marked by pixel_valid=1 two clocks later. Cycles with rdn=1 yield pixel_valid=0.
interface snake_pix_if #(
  parameter int COLOR_W = 12,
  parameter int ROW_W   = 9,
  parameter int COL_W   = 10,
  parameter int N_FOOD  = 2
);
  logic                      rdn;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          col;
  logic                      frame_start;
  logic                      snake_head;
  logic                      snake_body;
  logic [N_FOOD*COL_W-1:0]   food_x;
  logic [N_FOOD*ROW_W-1:0]   food_y;
  logic [N_FOOD-1:0]         food_en;
  logic [1:0]                mode;
  logic [COLOR_W-1:0]        pixel;
  logic                      pixel_valid;

  modport master (
    output rdn, row, col, frame_start, snake_head, snake_body,
           food_x, food_y, food_en, mode,
    input  pixel, pixel_valid
  );

  modport slave (
    input  rdn, row, col, frame_start, snake_head, snake_body,
           food_x, food_y, food_en, mode,
    output pixel, pixel_valid
  );
endinterface

// File: rtl/snake_pixel_compositor.sv
// Two-stage per-pixel compositor: S1 captures hit flags, display state and blink phase;
// S2 resolves the priority colour and applies pause dimming or game-over blinking.
module snake_pixel_compositor #(
  parameter int COLOR_W      = 12,
  parameter int ROW_W        = 9,
  parameter int COL_W        = 10,
  parameter int N_FOOD       = 2,
  parameter int BOX_HALF     = 10,
  parameter int BORDER_W     = 8,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 16,
  localparam int FC_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  snake_pix_if.slave      bus,
  output logic [1:0]      o_dbg_state,
  output logic            o_dbg_blink,
  output logic [FC_W-1:0] o_dbg_frame_cnt
);
  localparam int CW = COLOR_W / 3;
  localparam logic [COLOR_W-1:0] C_RED    = COLOR_W'({CW{1'b1}});
  localparam logic [COLOR_W-1:0] C_GREEN  = C_RED << CW;
  localparam logic [COLOR_W-1:0] C_BLUE   = C_RED << (2 * CW);
  localparam logic [COLOR_W-1:0] C_YELLOW = C_RED | C_GREEN;

  localparam logic [COL_W:0]   C_X_BW   = (COL_W + 1)'(BORDER_W);
  localparam logic [COL_W:0]   C_X_HI   = (COL_W + 1)'(H_ACTIVE - BORDER_W);
  localparam logic [COL_W:0]   C_X_ACT  = (COL_W + 1)'(H_ACTIVE);
  localparam logic [ROW_W:0]   C_Y_BW   = (ROW_W + 1)'(BORDER_W);
  localparam logic [ROW_W:0]   C_Y_HI   = (ROW_W + 1)'(V_ACTIVE - BORDER_W);
  localparam logic [ROW_W:0]   C_Y_ACT  = (ROW_W + 1)'(V_ACTIVE);
  localparam logic [COL_W-1:0] C_BH_X   = COL_W'(BOX_HALF);
  localparam logic [ROW_W-1:0] C_BH_Y   = ROW_W'(BOX_HALF);
  localparam logic [FC_W-1:0]  C_FC_TOP = FC_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_blink;
  logic              w_enter_over;
  logic [N_FOOD-1:0] w_food_hit;
  logic              w_food_any, w_border, w_outside;
  logic [COL_W:0]    w_col_x;
  logic [ROW_W:0]    w_row_x;
  logic              r_s1_vld, r_head, r_body, r_food, r_border, r_outside;
  logic [COLOR_W-1:0] w_base, w_dim, w_pix;
  logic              w_over_red;
  logic [COLOR_W-1:0] r_pixel;
  logic              r_pixel_valid;

  // Display state follows mode directly; the reserved code behaves as PLAY.
  always_comb begin
    w_state_nxt = ST_PLAY;
    case (bus.mode)
      2'd1:    w_state_nxt = ST_PAUSE;
      2'd2:    w_state_nxt = ST_OVER;
      default: w_state_nxt = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PLAY;
    else        r_state <= w_state_nxt;
  end

  assign w_enter_over = (w_state_nxt == ST_OVER) && (r_state != ST_OVER);

  // Entry clear beats a coincident frame_start; outside OVER the count is simply held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_enter_over) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if ((w_state_nxt == ST_OVER) && bus.frame_start) begin
      if (r_frame_cnt == C_FC_TOP) begin
        r_frame_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_FOOD; gi++) begin : g_food
    logic [COL_W-1:0] w_fx, w_lo_x;
    logic [ROW_W-1:0] w_fy, w_lo_y;
    logic [COL_W:0]   w_hi_x;
    logic [ROW_W:0]   w_hi_y;
    assign w_fx   = bus.food_x[gi*COL_W +: COL_W];
    assign w_fy   = bus.food_y[gi*ROW_W +: ROW_W];
    assign w_lo_x = (w_fx < C_BH_X) ? '0 : w_fx - C_BH_X;
    assign w_lo_y = (w_fy < C_BH_Y) ? '0 : w_fy - C_BH_Y;
    assign w_hi_x = {1'b0, w_fx} + {1'b0, C_BH_X};
    assign w_hi_y = {1'b0, w_fy} + {1'b0, C_BH_Y};
    assign w_food_hit[gi] = bus.food_en[gi]
                            && (bus.col >= w_lo_x) && ({1'b0, bus.col} <= w_hi_x)
                            && (bus.row >= w_lo_y) && ({1'b0, bus.row} <= w_hi_y);
  end

  assign w_food_any = |w_food_hit;
  assign w_col_x    = {1'b0, bus.col};
  assign w_row_x    = {1'b0, bus.row};
  assign w_border   = (w_col_x < C_X_BW) || (w_col_x >= C_X_HI)
                   || (w_row_x < C_Y_BW) || (w_row_x >= C_Y_HI);
  assign w_outside  = (w_col_x >= C_X_ACT) || (w_row_x >= C_Y_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_head    <= 1'b0;
      r_body    <= 1'b0;
      r_food    <= 1'b0;
      r_border  <= 1'b0;
      r_outside <= 1'b0;
    end else begin
      r_s1_vld  <= ~bus.rdn;
      r_head    <= bus.snake_head;
      r_body    <= bus.snake_body;
      r_food    <= w_food_any;
      r_border  <= w_border;
      r_outside <= w_outside;
    end
  end

  assign w_over_red = (r_state == ST_OVER) && r_blink;

  always_comb begin
    w_base = '0;
    if (r_outside)                           w_base = '0;
    else if (r_head)                         w_base = w_over_red ? C_RED : C_YELLOW;
    else if (r_body)                         w_base = w_over_red ? C_RED : C_GREEN;
    else if (r_food && (r_state != ST_OVER)) w_base = C_RED;
    else if (r_border)                       w_base = C_BLUE;
    w_dim = '0;
    for (int c = 0; c < 3; c++) w_dim[c*CW +: CW] = w_base[c*CW +: CW] >> 1;
    w_pix = (r_state == ST_PAUSE) ? w_dim : w_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_pixel       <= r_s1_vld ? w_pix : '0;
      r_pixel_valid <= r_s1_vld;
    end
  end

  assign bus.pixel       = r_pixel;
  assign bus.pixel_valid = r_pixel_valid;
  assign o_dbg_state     = r_state;
  assign o_dbg_blink     = r_blink;
  assign o_dbg_frame_cnt = r_frame_cnt;
endmodule
